// File: rtl/microsequencer.sv
// Next-address controller for the 128-word control-unit microstore.
// Selects the next microstore index from the ns field of the current
// microinstruction and datapath status. Includes a small LIFO return
// stack for microsubroutine call/return.
module microsequencer #(
  parameter logic [6:0] RESET_ADDR  = 7'd0,
  parameter logic [6:0] FETCH_ADDR  = 7'd1,
  parameter int         STACK_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic [2:0] ns,
  input  logic [6:0] cr,
  input  logic [1:0] cond_sel,
  input  logic       inv,
  input  logic       moc,
  input  logic       cond_true,
  input  logic       ext_cond,
  input  logic [6:0] decode_addr,
  output logic [6:0] index,
  output logic       stack_err,
  output logic [2:0] depth
);

  typedef enum logic [2:0] {
    NS_INC    = 3'b000,
    NS_JUMP   = 3'b001,
    NS_DECODE = 3'b010,
    NS_BRANCH = 3'b011,
    NS_CALL   = 3'b100,
    NS_RET    = 3'b101,
    NS_FETCH  = 3'b110,
    NS_WAIT   = 3'b111
  } ns_t;

  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  ns_t         op;
  logic [6:0]  inc_addr;
  logic        cond_raw;
  logic        cond;
  logic        full;
  logic        empty;
  logic [PW-1:0] top_ptr;
  logic [PW-1:0] wr_ptr;

  logic [6:0]  next_index;
  logic [2:0]  next_depth;
  logic        next_err;
  logic        push;

  logic [6:0]  stack [STACK_DEPTH];

  assign op       = ns_t'(ns);
  assign inc_addr = index + 7'd1;
  assign full     = (depth == 3'(STACK_DEPTH));
  assign empty    = (depth == 3'd0);
  assign top_ptr  = PW'(depth - 3'd1);
  assign wr_ptr   = PW'(depth);
  assign cond     = cond_raw ^ inv;

  // Condition source multiplexer.
  always_comb begin
    case (cond_sel)
      2'b00:   cond_raw = moc;
      2'b01:   cond_raw = cond_true;
      2'b10:   cond_raw = ext_cond;
      default: cond_raw = 1'b1;
    endcase
  end

  // Next-index, stack-occupancy and error selection from the ns field.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
    next_index = inc_addr;
    next_depth = depth;
    next_err   = stack_err;
    push       = 1'b0;
    case (op)
      NS_INC:    next_index = inc_addr;
      NS_JUMP:   next_index = cr;
      NS_DECODE: next_index = cond_true ? decode_addr : FETCH_ADDR;
      NS_BRANCH: next_index = cond ? cr : inc_addr;
      NS_CALL: begin
        push       = 1'b1;
        next_index = cr;
        if (full) next_err   = 1'b1;
        else      next_depth = depth + 3'd1;
      end
      NS_RET: begin
        if (empty) begin
          next_index = FETCH_ADDR;
          next_err   = 1'b1;
        end else begin
          next_index = stack[top_ptr];
          next_depth = depth - 3'd1;
        end
      end
      NS_FETCH:  next_index = FETCH_ADDR;
      NS_WAIT:   next_index = moc ? inc_addr : index;
      default:   next_index = inc_addr;
    endcase
  end

  // Index, depth and sticky error register; reset wins, stall freezes.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      index     <= RESET_ADDR;
      depth     <= 3'd0;
      stack_err <= 1'b0;
    end else if (!stall) begin
      index     <= next_index;
      depth     <= next_depth;
      stack_err <= next_err;
    end
  end

  // Return-stack storage; a push onto a full stack drops the oldest entry.
  always_ff @(posedge clk) begin
    // NOTE: stack contents are deliberately not reset; depth alone says which entries are valid.
    if (!reset && !stall && push) begin
      if (full) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) stack[i] <= stack[i+1];
        stack[STACK_DEPTH-1] <= inc_addr;
      end else begin
        stack[wr_ptr] <= inc_addr;
      end
    end
  end

endmodule
